// File: rtl/icini_mul_pipe.sv
// Two-stage masked, fault-aware AND gadget: refresh + majority-correct b, detect codeword faults,
// remask cross-domain products, recombine c shares from the product register.
module icini_mul_pipe #(
  parameter int D   = 1,
  parameter int N   = 3,
  parameter int FCW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [(D+1)*N-1:0]   a_sh,
  input  logic [(D+1)*N-1:0]   b_sh,
  input  logic [D-1:0]         rand_ref,
  input  logic [D*(D+1)/2-1:0] rand_mul,
  input  logic                 fault_clear,
  output logic [(D+1)*N-1:0]   c_sh,
  output logic                 out_valid,
  output logic                 fault_flag,
  output logic [FCW-1:0]       fault_cnt
);

  localparam int S  = D + 1;
  localparam int SN = S * N;
  localparam int TW = S * S * N;

  function automatic logic maj_bit(input logic [N-1:0] cw);
    int ones;
    ones = 0;
    for (int k = 0; k < N; k++) begin
      ones = ones + int'(cw[k]);
    end
    return (ones > (N / 2));
  endfunction

  function automatic logic cw_bad(input logic [N-1:0] cw);
    return (cw != {N{1'b0}}) && (cw != {N{1'b1}});
  endfunction

  // Lexicographic index of pair (lo,hi), lo<hi, into rand_mul
  function automatic int pair_idx(input int lo, input int hi);
    return lo * S - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic [S-1:0]   ref_bits_s;
  logic [N-1:0]   br_s;
  logic [SN-1:0]  b_corr_s;
  logic           det_s;
  logic           fault_set_s;

  logic [SN-1:0]  a1_d, a1_q, b1_d, b1_q;
  logic           v1_d, v1_q;
  logic [TW-1:0]  t_d, t_q;
  logic           v2_d, v2_q;
  logic           flag_d, flag_q;
  logic [FCW-1:0] cnt_d, cnt_q;
  logic [N-1:0]   prod_s;

  // Stage 1: refresh b, majority-correct it, and flag any inconsistent codeword
  always_comb begin
    ref_bits_s = {^rand_ref, rand_ref};
    br_s       = {N{1'b0}};
    b_corr_s   = {SN{1'b0}};
    det_s      = 1'b0;
    for (int i = 0; i < S; i++) begin
      br_s = b_sh[i*N +: N] ^ {N{ref_bits_s[i]}};
      b_corr_s[i*N +: N] = {N{maj_bit(br_s)}};
      det_s = det_s | cw_bad(a_sh[i*N +: N]) | cw_bad(br_s);
    end
  end

  // Stage 1 register and fault bookkeeping next-state
  always_comb begin
    v1_d        = in_valid;
    fault_set_s = in_valid & det_s;
    if (in_valid) begin
      a1_d = a_sh;
      b1_d = b_corr_s;
    end else begin
      a1_d = a1_q;
      b1_d = b1_q;
    end
    if (fault_set_s && (cnt_q != {FCW{1'b1}})) begin
      cnt_d = cnt_q + FCW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
    // Set has priority over clear
    if (fault_set_s) begin
      flag_d = 1'b1;
    end else if (fault_clear) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Stage 2: remasked cross-domain products t_ij at slot (i*S+j)
  always_comb begin
    t_d    = t_q;
    v2_d   = v1_q;
    prod_s = {N{1'b0}};
    if (v1_q) begin
      for (int i = 0; i < S; i++) begin
        for (int j = 0; j < S; j++) begin
          prod_s = a1_q[i*N +: N] & b1_q[j*N +: N];
          if (i < j) begin
            t_d[(i*S+j)*N +: N] = prod_s ^ {N{rand_mul[pair_idx(i, j)]}};
          end else if (i > j) begin
            t_d[(i*S+j)*N +: N] = prod_s ^ {N{rand_mul[pair_idx(j, i)]}};
          end else begin
            t_d[(i*S+j)*N +: N] = prod_s;
          end
        end
      end
    end else begin
      t_d = t_q;
    end
  end

  // Pipeline and fault state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1_q   <= {SN{1'b0}};
      b1_q   <= {SN{1'b0}};
      v1_q   <= 1'b0;
      t_q    <= {TW{1'b0}};
      v2_q   <= 1'b0;
      flag_q <= 1'b0;
      cnt_q  <= {FCW{1'b0}};
    end else begin
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      v1_q   <= v1_d;
      t_q    <= t_d;
      v2_q   <= v2_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output recombination: pure XOR tree over the product register
  always_comb begin
    c_sh = {SN{1'b0}};
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        c_sh[i*N +: N] = c_sh[i*N +: N] ^ t_q[(i*S+j)*N +: N];
      end
    end
  end

  assign out_valid  = v2_q;
  assign fault_flag = flag_q;
  assign fault_cnt  = cnt_q;

endmodule
